// File: rtl/batch_acc_pkg.sv
// Package shared by the batch accumulator and its result RAM.
// Contents:
//   state_t    - acquisition state machine encoding
//   acc_width  - width of a coherent sum of `runs` signed samples of `dw` bits
package batch_acc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RECV  = 3'd2,
    GAP   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_t;

  // Growth of log2(runs+1) bits keeps the sum of `runs` samples free of overflow.
  function automatic int acc_width(input int dw, input int runs);
    return dw + $clog2(runs + 1);
  endfunction

endpackage

// File: rtl/acc_ram.sv
// Result memory for the batch accumulator: DEPTH x WIDTH, one write port and one
// registered read port shared between the read-modify-write pipeline and readout.
// Ports:
//   clk      - rising-edge clock
//   a_ren    - pipeline read request (takes priority over the readout address)
//   a_raddr  - pipeline read address
//   a_wen    - pipeline write enable
//   a_waddr  - pipeline write address
//   a_wdata  - pipeline write data
//   b_addr   - readout address, served whenever the pipeline is not reading
//   q_r      - registered read data (1-cycle latency)
module acc_ram #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             a_ren,
  input  logic [AW-1:0]    a_raddr,
  input  logic             a_wen,
  input  logic [AW-1:0]    a_waddr,
  input  logic [WIDTH-1:0] a_wdata,
  input  logic [AW-1:0]    b_addr,
  output logic [WIDTH-1:0] q_r
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    raddr_s;

  // Read address select: accumulation reads win, readout uses idle cycles.
  always_comb begin
    raddr_s = b_addr;
    if (a_ren) begin
      raddr_s = a_raddr;
    end else begin
      raddr_s = b_addr;
    end
  end

  // Write port.
  always_ff @(posedge clk) begin
    if (a_wen) begin
      mem_r[a_waddr] <= a_wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    q_r <= mem_r[raddr_s];
  end

endmodule

// File: rtl/batch_accumulator.sv
// Streaming sink that requests packets of BATCH_SIZE signed samples from the
// upstream source, sums RUNS consecutive packets sample-wise into acc_ram and
// exposes the sums through a 1-cycle-latency read port. Framing violations
// latch frame_error and park the block in ERROR until reset.
// Optional feature macro: BATCH_ACC_PEAK_EN adds peak_value/peak_index, the
// largest sum written during the final run (lowest index on ties).
// Ports:
//   sink_clk, reset          - clock, synchronous active-high reset
//   upstream_ready / start   - upstream handshake (start registered)
//   sink_sop/eop/valid/data  - packet stream
//   clear                    - leave DONE and begin a new acquisition
//   done, frame_error        - status (registered)
//   rd_addr / rd_data        - result readout
module batch_accumulator
  import batch_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int BATCH_SIZE = 2048,
  parameter int RUNS       = 3,
  parameter int GAP_CYCLES = 100,
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, RUNS),
  localparam int AW        = $clog2(BATCH_SIZE)
) (
  input  logic                        sink_clk,
  input  logic                        reset,
  input  logic                        upstream_ready,
  output logic                        start,
  input  logic                        sink_sop,
  input  logic                        sink_eop,
  input  logic                        sink_valid,
  input  logic [DATA_WIDTH-1:0]       sink_data,
  input  logic                        clear,
  output logic                        done,
  output logic                        frame_error,
  input  logic [AW-1:0]               rd_addr,
  output logic signed [ACC_WIDTH-1:0] rd_data
`ifdef BATCH_ACC_PEAK_EN
  ,
  output logic signed [ACC_WIDTH-1:0] peak_value,
  output logic [AW-1:0]               peak_index
`endif
);

  localparam int RW = $clog2(RUNS + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(BATCH_SIZE - 1);

  state_t                        state_r;
  logic [RW-1:0]                 run_r;
  logic [AW-1:0]                 index_r;
  logic [GW-1:0]                 gap_cnt_r;
  logic                          drain_cnt_r;
  logic                          accept_s;
  logic                          bad_s;
  logic                          last_idx_s;
  logic                          s1_vld_r;
  logic                          s1_first_r;
  logic [AW-1:0]                 s1_addr_r;
  logic signed [DATA_WIDTH-1:0]  s1_data_r;
  logic signed [ACC_WIDTH-1:0]   ram_q_s;
  logic signed [ACC_WIDTH-1:0]   sum_s;

  assign last_idx_s = (index_r == LAST_IDX);

  // Beat classification: accepted data beat or framing violation.
  always_comb begin
    accept_s = 1'b0;
    bad_s    = 1'b0;
    case (state_r)
      ARM: begin
        // Opening beat must carry sop; an eop here can never be at the last index.
        if (sink_valid) begin
          if (sink_sop && !sink_eop) begin
            accept_s = 1'b1;
          end else begin
            bad_s = 1'b1;
          end
        end else begin
          accept_s = 1'b0;
        end
      end
      RECV: begin
        // eop must coincide exactly with the last index.
        if (sink_valid) begin
          if (sink_sop) begin
            bad_s = 1'b1;
          end else if (sink_eop != last_idx_s) begin
            bad_s = 1'b1;
          end else begin
            accept_s = 1'b1;
          end
        end else begin
          accept_s = 1'b0;
        end
      end
      IDLE, GAP, DRAIN, DONE: bad_s = sink_valid;
      default: begin
        accept_s = 1'b0;
        bad_s    = 1'b0;
      end
    endcase
  end

  // Acquisition state machine with registered start/done/frame_error.
  always_ff @(posedge sink_clk) begin
    if (reset) begin
      state_r     <= IDLE;
      start       <= 1'b0;
      done        <= 1'b0;
      frame_error <= 1'b0;
      run_r       <= '0;
      index_r     <= '0;
      gap_cnt_r   <= '0;
      drain_cnt_r <= 1'b0;
    end else if (bad_s) begin
      state_r     <= ERROR;
      start       <= 1'b0;
      done        <= 1'b0;
      frame_error <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (upstream_ready) begin
            state_r <= ARM;
            start   <= 1'b1;
            run_r   <= '0;
            index_r <= '0;
          end
        end
        ARM: begin
          if (accept_s) begin
            state_r <= RECV;
            index_r <= index_r + AW'(1);
          end
        end
        RECV: begin
          if (accept_s && last_idx_s) begin
            start       <= 1'b0;
            index_r     <= '0;
            run_r       <= run_r + RW'(1);
            gap_cnt_r   <= '0;
            drain_cnt_r <= 1'b0;
            if (run_r == RW'(RUNS - 1)) begin
              state_r <= DRAIN;
            end else begin
              state_r <= GAP;
            end
          end else if (accept_s) begin
            index_r <= index_r + AW'(1);
          end
        end
        GAP: begin
          if (gap_cnt_r == GW'(GAP_CYCLES - 1)) begin
            state_r <= ARM;
            start   <= 1'b1;
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
          end
        end
        DRAIN: begin
          // Two cycles let the last beat's read-add-write retire.
          if (drain_cnt_r) begin
            state_r <= DONE;
            done    <= 1'b1;
          end else begin
            drain_cnt_r <= 1'b1;
          end
        end
        DONE: begin
          if (clear) begin
            state_r <= ARM;
            start   <= 1'b1;
            done    <= 1'b0;
            run_r   <= '0;
          end
        end
        ERROR: begin
          start       <= 1'b0;
          frame_error <= 1'b1;
        end
        default: begin
          state_r     <= ERROR;
          start       <= 1'b0;
          frame_error <= 1'b1;
        end
      endcase
    end
  end

  // Stage 1: capture the accepted beat while the RAM read of its bin is issued.
  always_ff @(posedge sink_clk) begin
    if (reset) begin
      s1_vld_r   <= 1'b0;
      s1_first_r <= 1'b0;
      s1_addr_r  <= '0;
      s1_data_r  <= '0;
    end else begin
      s1_vld_r   <= accept_s;
      s1_first_r <= (run_r == '0);
      s1_addr_r  <= index_r;
      s1_data_r  <= sink_data;
    end
  end

  // Stage 2: first run overwrites stale RAM contents, later runs accumulate.
  always_comb begin
    sum_s = ACC_WIDTH'(s1_data_r);
    if (s1_first_r) begin
      sum_s = ACC_WIDTH'(s1_data_r);
    end else begin
      sum_s = ram_q_s + ACC_WIDTH'(s1_data_r);
    end
  end

  acc_ram #(
    .DEPTH (BATCH_SIZE),
    .WIDTH (ACC_WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk     (sink_clk),
    .a_ren   (accept_s),
    .a_raddr (index_r),
    .a_wen   (s1_vld_r),
    .a_waddr (s1_addr_r),
    .a_wdata (sum_s),
    .b_addr  (rd_addr),
    .q_r     (ram_q_s)
  );

  assign rd_data = ram_q_s;

`ifdef BATCH_ACC_PEAK_EN
  logic s1_final_r;
  logic acq_start_s;

  // A new acquisition begins when leaving IDLE or DONE toward ARM.
  always_comb begin
    acq_start_s = 1'b0;
    if (!reset && !bad_s && (((state_r == IDLE) && upstream_ready) || ((state_r == DONE) && clear))) begin
      acq_start_s = 1'b1;
    end else begin
      acq_start_s = 1'b0;
    end
  end

  // Marks stage-1 beats belonging to the final run.
  always_ff @(posedge sink_clk) begin
    if (reset) begin
      s1_final_r <= 1'b0;
    end else begin
      s1_final_r <= (run_r == RW'(RUNS - 1));
    end
  end

  // Peak tracker: strict compare keeps the lowest index because writes ascend.
  always_ff @(posedge sink_clk) begin
    if (reset || acq_start_s) begin
      peak_value <= {1'b1, {(ACC_WIDTH-1){1'b0}}};
      peak_index <= '0;
    end else if (s1_vld_r && s1_final_r && (sum_s > peak_value)) begin
      peak_value <= sum_s;
      peak_index <= s1_addr_r;
    end
  end
`endif

endmodule
